// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, assembles nibbles into payload bytes
// and reports per-frame length, error status and a running frame count.
module rgmii_rx_framer #(
    parameter int MAX_BYTES = 1522,
    parameter int LEN_W     = 11
) (
    input  logic             rgm0_clk,
    input  logic             rgm0_rst,
    input  logic             rgm0_en,
    input  logic [3:0]       rgm0_d,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_t           state, state_nx;
    logic             phase;
    logic [3:0]       lo_nib;
    logic [LEN_W-1:0] byte_cnt;
    logic             ovl;

    logic take_lo, emit, start, set_ovl, fin, fin_ovl;

    always_comb begin
        state_nx = state;
        take_lo  = 1'b0;
        emit     = 1'b0;
        start    = 1'b0;
        set_ovl  = 1'b0;
        fin      = 1'b0;
        fin_ovl  = 1'b0;
        case (state)
            IDLE: begin
                if (rgm0_en) state_nx = (rgm0_d == 4'h5) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rgm0_en) begin
                    state_nx = IDLE;
                end else if (rgm0_d == 4'hD) begin
                    state_nx = DATA;
                    start    = 1'b1;
                end else if (rgm0_d != 4'h5) begin
                    state_nx = DROP;
                end
            end
            DATA: begin
                if (!rgm0_en) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end else if (!phase) begin
                    take_lo = 1'b1;
                end else if (byte_cnt == MAX_LEN) begin
                    // Overlength: stop delivering, report once the frame ends.
                    set_ovl  = 1'b1;
                    state_nx = DROP;
                end else begin
                    emit = 1'b1;
                end
            end
            DROP: begin
                if (!rgm0_en) begin
                    fin_ovl  = ovl;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge rgm0_clk or posedge rgm0_rst) begin
        if (rgm0_rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            lo_nib     <= 4'h0;
            byte_cnt   <= '0;
            ovl        <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_err  <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            state      <= state_nx;
            rx_valid   <= emit;
            rx_sof     <= emit && (byte_cnt == '0);
            frame_done <= fin | fin_ovl;
            if (start) begin
                phase    <= 1'b0;
                byte_cnt <= '0;
                ovl      <= 1'b0;
            end
            if (take_lo) begin
                lo_nib <= rgm0_d;
                phase  <= 1'b1;
            end
            if (emit) begin
                rx_data  <= {rgm0_d, lo_nib};
                phase    <= 1'b0;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (set_ovl) ovl <= 1'b1;
            if (fin) begin
                frame_len <= byte_cnt;
                frame_err <= phase;
                frame_cnt <= frame_cnt + 16'd1;
                phase     <= 1'b0;
            end
            if (fin_ovl) begin
                frame_len <= MAX_LEN;
                frame_err <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
                ovl       <= 1'b0;
            end
        end
    end

endmodule
